// File: rtl/ece429_pipelined_memory.sv
// Byte-addressed big-endian unified memory with LATENCY-deep response pipe.
// Ports: clock/reset, req_* (valid/addr/wdata/size/rw/signed), resp_* (valid/rdata/err).
module ece429_pipelined_memory #(
  parameter logic [31:0] BASE_ADDR  = 32'h80020000,
  parameter int          SIZE_BYTES = 1048576,
  parameter int          LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [0:31] req_addr,
  input  logic [0:31] req_wdata,
  input  logic [0:1]  req_size,
  input  logic        req_rw,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [0:31] resp_rdata,
  output logic        resp_err
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("ece429_pipelined_memory: LATENCY must be 1..4");
  end

  localparam int          AW = $clog2(SIZE_BYTES);
  localparam logic [31:0] SZ = 32'(SIZE_BYTES);

  logic [7:0]    mem_q [SIZE_BYTES];

  logic [31:0]   idx;
  logic [31:0]   nbytes;
  logic          is_word;
  logic          is_half;
  logic          in_rng;
  logic          misal;
  logic          err_d;
  logic [AW-1:0] i0;
  logic [AW-1:0] i1;
  logic [AW-1:0] i2;
  logic [AW-1:0] i3;
  logic [7:0]    b0;
  logic [7:0]    b1;
  logic [7:0]    b2;
  logic [7:0]    b3;
  logic [31:0]   rd_d;

  logic          vld_q [LATENCY];
  logic [31:0]   dat_q [LATENCY];
  logic          err_q [LATENCY];

  always_comb begin
    is_word = (req_size == 2'b11);
    is_half = (req_size == 2'b10);
    idx     = req_addr - BASE_ADDR;
    nbytes  = 32'd1;
    unique case (1'b1)
      is_word: nbytes = 32'd4;
      is_half: nbytes = 32'd2;
      default: nbytes = 32'd1;
    endcase
    // Compare against SZ - nbytes so the top of the array never wraps.
    in_rng = (idx <= (SZ - nbytes));
    misal  = (is_word && (idx[1:0] != 2'b00))
           || (is_half && idx[0]);
    err_d  = !in_rng || misal;
    i0 = idx[AW-1:0];
    i1 = i0 + AW'(1);
    i2 = i0 + AW'(2);
    i3 = i0 + AW'(3);
    b0 = mem_q[i0];
    b1 = mem_q[i1];
    b2 = mem_q[i2];
    b3 = mem_q[i3];
    rd_d = '0;
    if (!err_d && !req_rw) begin
      unique case (1'b1)
        is_word: rd_d = {b0, b1, b2, b3};
        is_half: rd_d = {{16{req_signed & b0[7]}}, b0, b1};
        default: rd_d = {{24{req_signed & b0[7]}}, b0};
      endcase
    end
  end

  // Array is never reset; writes issued during reset are dropped.
  always_ff @(posedge clock) begin
    if (!reset && req_valid && req_rw && !err_d) begin
      unique case (1'b1)
        is_word: begin
          mem_q[i0] <= req_wdata[0:7];
          mem_q[i1] <= req_wdata[8:15];
          mem_q[i2] <= req_wdata[16:23];
          mem_q[i3] <= req_wdata[24:31];
        end
        is_half: begin
          mem_q[i0] <= req_wdata[16:23];
          mem_q[i1] <= req_wdata[24:31];
        end
        default: mem_q[i0] <= req_wdata[24:31];
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= '0;
        err_q[k] <= 1'b0;
      end
    end else begin
      vld_q[0] <= req_valid;
      dat_q[0] <= req_valid ? rd_d : '0;
      err_q[0] <= req_valid & err_d;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
        err_q[k] <= err_q[k-1];
      end
    end
  end

  assign resp_valid = vld_q[LATENCY-1];
  assign resp_rdata = dat_q[LATENCY-1];
  assign resp_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_ece429_pipelined_memory.sv
// Scoreboard bench: three memories (LATENCY 1/3/4) share one request stream.
// Each expected response carries its due cycle so latency and order are checked.
module tb_ece429_pipelined_memory;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [0:31] req_addr;
  logic [0:31] req_wdata;
  logic [0:1]  req_size;
  logic        req_rw;
  logic        req_signed;

  logic        rv0, rv1, rv2;
  logic [0:31] rd0, rd1, rd2;
  logic        re0, re1, re2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ece429_pipelined_memory #(.LATENCY(1)) u_l1 (
    .clock(clk), .reset(reset), .req_valid(req_valid),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_rw(req_rw),
    .req_signed(req_signed), .resp_valid(rv0),
    .resp_rdata(rd0), .resp_err(re0));

  ece429_pipelined_memory #(.LATENCY(3)) u_l3 (
    .clock(clk), .reset(reset), .req_valid(req_valid),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_rw(req_rw),
    .req_signed(req_signed), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_err(re1));

  ece429_pipelined_memory #(.LATENCY(4)) u_l4 (
    .clock(clk), .reset(reset), .req_valid(req_valid),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_rw(req_rw),
    .req_signed(req_signed), .resp_valid(rv2),
    .resp_rdata(rd2), .resp_err(re2));

  task automatic cmp(input int lat, input logic have, input exp_t x,
                     input logic [31:0] rd, input logic er);
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL L%0d unexpected_resp: got err=%0b rdata=%h at cyc %0d, want none",
               lat, er, rd, cyc);
    end else if (rd !== x.d || er !== x.e || cyc !== x.due) begin
      miscompares++;
      $display("FAIL L%0d resp: got err=%0b rdata=%h cyc=%0d, want err=%0b rdata=%h cyc=%0d",
               lat, er, rd, cyc, x.e, x.d, x.due);
    end
  endtask

  always @(negedge clk) if (rv0 === 1'b1) begin
    if (q0.size() == 0) cmp(1, 1'b0, '0, rd0, re0);
    else cmp(1, 1'b1, q0.pop_front(), rd0, re0);
  end
  always @(negedge clk) if (rv1 === 1'b1) begin
    if (q1.size() == 0) cmp(3, 1'b0, '0, rd1, re1);
    else cmp(3, 1'b1, q1.pop_front(), rd1, re1);
  end
  always @(negedge clk) if (rv2 === 1'b1) begin
    if (q2.size() == 0) cmp(4, 1'b0, '0, rd2, re2);
    else cmp(4, 1'b1, q2.pop_front(), rd2, re2);
  end

  task automatic drive(input logic [31:0] a, input logic [1:0] sz,
                       input logic rw, input logic [31:0] wd,
                       input logic sg);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_rw     = rw;
    req_wdata  = wd;
    req_signed = sg;
  endtask

  task automatic req(input logic [31:0] a, input logic [1:0] sz,
                     input logic rw, input logic [31:0] wd,
                     input logic sg, input logic [31:0] ed,
                     input logic ee);
    drive(a, sz, rw, wd, sg);
    q0.push_back('{d: ed, e: ee, due: cyc + 1});
    q1.push_back('{d: ed, e: ee, due: cyc + 3});
    q2.push_back('{d: ed, e: ee, due: cyc + 4});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_quiet(input string nm, input logic v,
                           input logic [31:0] d, input logic e);
    vectors++;
    if (v !== 1'b0 || d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got valid=%0b rdata=%h err=%0b, want 0/0/0",
               nm, v, d, e);
    end
  endtask

  localparam logic [31:0] B   = 32'h80020000;
  localparam logic [31:0] TOP = 32'h80120000;

  initial begin
    reset = 1'b1;
    drive(B, 2'b11, 1'b0, 32'h0, 1'b0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset_l1", rv0, rd0, re0);
    chk_quiet("reset_l3", rv1, rd1, re1);
    chk_quiet("reset_l4", rv2, rd2, re2);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    req(B,      2'b11, 1, 32'hDEADBEEF, 0, 32'h0,        0);
    req(B,      2'b11, 0, 32'h0,        0, 32'hDEADBEEF, 0);
    req(B + 3,  2'b00, 0, 32'h0,        0, 32'h000000EF, 0);
    req(B,      2'b10, 0, 32'h0,        1, 32'hFFFFDEAD, 0);
    req(B,      2'b10, 0, 32'h0,        0, 32'h0000DEAD, 0);
    req(B + 1,  2'b01, 0, 32'h0,        1, 32'hFFFFFFAD, 0);
    req(B + 4,  2'b11, 1, 32'h11223344, 0, 32'h0,        0);
    req(B + 8,  2'b11, 1, 32'h85667788, 0, 32'h0,        0);
    idle(1);
    req(B,      2'b11, 0, 32'h0,        0, 32'hDEADBEEF, 0);
    req(B + 4,  2'b11, 0, 32'h0,        0, 32'h11223344, 0);
    req(B + 8,  2'b11, 0, 32'h0,        0, 32'h85667788, 0);
    req(B + 10, 2'b10, 0, 32'h0,        1, 32'h00007788, 0);
    req(B + 8,  2'b00, 0, 32'h0,        1, 32'hFFFFFF85, 0);
    req(B + 2,  2'b11, 0, 32'h0,        0, 32'h0,        1);
    req(B + 1,  2'b10, 1, 32'h0000ABCD, 0, 32'h0,        1);
    req(B,      2'b11, 0, 32'h0,        0, 32'hDEADBEEF, 0);
    req(TOP - 2, 2'b11, 0, 32'h0,       0, 32'h0,        1);
    req(TOP - 1, 2'b00, 1, 32'h00000077, 0, 32'h0,       0);
    req(TOP - 1, 2'b00, 0, 32'h0,       0, 32'h00000077, 0);
    req(TOP,    2'b00, 0, 32'h0,        0, 32'h0,        1);
    req(32'h7FFFFFFC, 2'b11, 0, 32'h0,  0, 32'h0,        1);
    req(B + 16, 2'b00, 1, 32'h0000005A, 0, 32'h0,        0);
    req(B + 16, 2'b00, 0, 32'h0,        0, 32'h0000005A, 0);
    idle(6);

    req(B,      2'b11, 0, 32'h0,        0, 32'hDEADBEEF, 0);
    req(B + 16, 2'b00, 0, 32'h0,        0, 32'h0000005A, 0);
    reset = 1'b1;
    drive(B + 16, 2'b00, 1'b1, 32'h000000FF, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (6) begin
      @(negedge clk);
      chk_quiet("flush_l4", rv2, rd2, re2);
    end
    @(posedge clk); #1;
    req(B,      2'b11, 0, 32'h0,        0, 32'hDEADBEEF, 0);
    req(B + 16, 2'b00, 0, 32'h0,        0, 32'h0000005A, 0);

    for (int t = 0; t < 20; t++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d responses outstanding, want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ece429_pipelined_memory.md
Name: ece429_pipelined_memory

Overview:
Parametrised byte-addressed, big-endian unified memory model for the MIPS processor datapath. Accepts one request per cycle (read or write; byte/half/word) with a valid qualifier. Returns a response after a configurable read latency, with signed/unsigned load extension and misalignment/range error reporting. Successor to the fixed 1 MB single-cycle memory; serves both the fetch and memory stages.

Parameters:
BASE_ADDR, 32'h80020000, byte address mapped to array index 0
SIZE_BYTES, 1048576, array depth in bytes; power of two, >= 4
LATENCY, 1, cycles from request edge to resp_valid; legal 1..4

Ports:
clock  input  1  rising-edge clock; all state updates on posedge
reset  input  1  synchronous, active-high
req_valid  input  1  request present this cycle
req_addr  input  [0:31]  byte address, bit 0 = MSB
req_wdata  input  [0:31]  write data; byte/half taken from low-order bits [24:31]/[16:31]
req_size  input  [0:1]  11 word, 10 half-word, 01/00 byte
req_rw  input  1  0 read, 1 write
req_signed  input  1  1 sign-extend byte/half loads, 0 zero-extend
resp_valid  output  1  response for request issued LATENCY cycles earlier
resp_rdata  output  [0:31]  load data (0 for writes and errored requests)
resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset: resp_valid=0, resp_rdata=0, resp_err=0; all pipeline stage valids cleared. Memory array contents are not cleared. Requests presented while reset=1 are dropped and never complete.
- Index = req_addr - BASE_ADDR (32-bit wrap arithmetic). In range iff index <= SIZE_BYTES - (access bytes).
- Misaligned: word with index[30:31] != 0; half with index[31] != 0. Byte is never misaligned.
- Error (misaligned or out of range): no array write, rdata=0, resp_err=1 on the response.
- Write: committed at the posedge that samples req_valid=1, req_rw=1. Big-endian: word -> mem[i]=wdata[0:7] .. mem[i+3]=wdata[24:31]; half -> mem[i]=wdata[16:23], mem[i+1]=wdata[24:31]; byte -> mem[i]=wdata[24:31]. Write still produces a response (resp_valid, rdata=0) after LATENCY.
- Read: array sampled at the accepting posedge, after any write committed at an earlier edge. Word = {mem[i],mem[i+1],mem[i+2],mem[i+3]}; half = {ext16, mem[i], mem[i+1]}; byte = {ext24, mem[i]}. ext = replicated MSB of loaded value if req_signed=1, else zeros.
- Pipeline: LATENCY-deep shift register of {valid, rdata, err}. Fully pipelined; one request accepted per cycle; no backpressure; responses strictly in request order.
- resp_valid=0 on cycles with no matured request; resp_rdata and resp_err are then 0.
- Read immediately following a write to the same address (next cycle) returns the new data.
- Reset mid-operation: all in-flight responses discarded; first post-reset response can appear no earlier than LATENCY cycles after the first accepted post-reset request.
- LATENCY outside 1..4 is a configuration error: elaboration-time $error.

Test Plan:
- LATENCY=1: write word 32'hDEADBEEF at 80020000, then read word -> resp_valid one cycle after each request; read rdata=DEADBEEF, err=0; byte read at 80020003 -> 000000EF.
- Signed loads: after that write, half read at 80020000 with req_signed=1 -> FFFFDEAD; req_signed=0 -> 0000DEAD; signed byte at 80020001 -> FFFFFFAD.
- LATENCY=3: back-to-back reads of 80020000, 80020004, 80020008 on consecutive cycles -> three consecutive resp_valid beats starting 3 cycles after the first, in order, with the correct data.
- Errors: word read at 80020002 -> err=1, rdata=0; half write at 80020001 -> err=1, memory unchanged (verified by a later read); word read at 80020000+SIZE_BYTES-2 -> err=1; address 7FFFFFFC -> err=1.
- Write-then-read: byte write 8'h5A to 80020010 at cycle n, byte read at cycle n+1 -> 0000005A.
- Reset mid-flight with LATENCY=4: issue 2 reads, assert reset for 1 cycle -> no resp_valid for those reads; memory retains data written before reset.
